low_out_buffer: RTL

- Downstream consumer of the timer-driven L/H state machine's 16-bit low output word.
- Captures words only during L-mode windows (mode == 0) and buffers them in a small FIFO.
- Drains the FIFO to a low-security sink through a valid/ready handshake.
- Every port and every internal register is labelled {L}, so no H-derived value or timing reaches the sink.

---
 rtl/low_out_buffer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/low_out_buffer.sv
// low_out_buffer
//   Captures the upstream FSM's low output word during L windows (mode == 0)
//   into a small FIFO and drains it to a low sink over valid/ready.
//   Words offered during H windows are never stored. They are only counted.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   in_data        upstream low word
//   in_valid       upstream word valid
//   mode           0 = L window (capture), 1 = H window (gate)
//   out_data       head-of-FIFO word (0 when empty)
//   out_valid      FIFO non-empty
//   out_ready      sink accepts out_data this cycle
//   count          occupancy, 0..DEPTH
//   drop_cnt       saturating count of words refused while full
//   h_gate_cnt     saturating count of in_valid cycles gated by mode == 1
module low_out_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNTW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             mode,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNTW-1:0]  count,
    output logic [7:0]       drop_cnt,
    output logic [7:0]       h_gate_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ACCEPT = 1'b0,
        GATED  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_gated;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNTW-1:0]  r_count;
    logic [7:0]       r_drop_cnt;
    logic [7:0]       r_h_gate_cnt;

    logic             w_nonempty;
    logic             w_full;
    logic             w_push_req;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    // Push side uses the live mode, so a word offered in the first H cycle
    // is already refused.
    assign w_nonempty = (r_count != '0);
    assign w_full     = (r_count == CNTW'(DEPTH));
    assign w_push_req = in_valid & ~mode;
    assign w_pop      = w_nonempty & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    // Gate-state FSM. The counter qualifies on the next state, which makes
    // the first in_valid cycle of an H window count as gated.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ACCEPT:  if (mode)  w_next_state = GATED;
            GATED:   if (!mode) w_next_state = ACCEPT;
            default: w_next_state = ACCEPT;
        endcase
        w_gated = (w_next_state == GATED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ACCEPT;
        else     r_state <= w_next_state;
    end

    // Storage is left unreset. out_data masks it whenever count == 0.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_drop_cnt   <= '0;
            r_h_gate_cnt <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop && r_drop_cnt != 8'hFF)
                r_drop_cnt <= r_drop_cnt + 8'd1;
            if (in_valid && w_gated && r_h_gate_cnt != 8'hFF)
                r_h_gate_cnt <= r_h_gate_cnt + 8'd1;
        end
    end

    // Outputs depend only on registered state. With count reset
    // asynchronously, both out_valid and out_data drop at once.
    assign out_valid  = w_nonempty;
    assign out_data   = w_nonempty ? r_mem[r_rd_ptr] : '0;
    assign count      = r_count;
    assign drop_cnt   = r_drop_cnt;
    assign h_gate_cnt = r_h_gate_cnt;

endmodule
